encryption: RTL and testbench
=============================

Name: encryption

Overview:
- Byte-serial two-key Triple-DES engine behind the I2C slave.
- Collects key1, key2 and a 64-bit data block one byte at a time from the I2C byte interface.
- Runs EDE (encrypt) or DED (decrypt) using an iterative one-round-per-cycle DES datapath.
- Presents the 64-bit result to the I2C transmit side with a ready flag.

Parameters:
- None. Widths are fixed by DES: 64-bit block, 64-bit key with parity bits ignored, 8-bit byte port.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i2c_stop  input  1  0 = key-loading phase, 1 = data phase
- i2c_rw  input  1  0 = encrypt, 1 = decrypt; sampled when the 8th data byte is captured
- i2c_input  input  8  received byte
- read_enable  input  1  byte strobe; every cycle it is high, i2c_input is captured
- i2c_output  output  64  Triple-DES result
- output_ready  output  1  result valid

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: i2c_output=0, output_ready=0, key1=key2=data=0, byte counters=0, FSM=IDLE. Reset mid-computation aborts it with no output.
- Byte assembly: MSB-first. On capture, reg <= {reg[55:0], i2c_input}.
- Key phase (i2c_stop=0):
  - 4-bit key counter; bytes 0-7 go to key1, bytes 8-15 go to key2.
  - The counter wraps to 0 after 16.
  - While i2c_stop=1 the key counter is held at 0.
- Data phase (i2c_stop=1):
  - 3-bit data counter shifts bytes into the data register.
  - While i2c_stop=0 the data counter is held at 0.
  - The capture of the 8th byte latches i2c_rw and starts computation on the next cycle.
  - output_ready clears on the first data byte captured.
- Busy: byte strobes during computation (either phase) are ignored and counters do not advance. Keys are used as latched at start.
- Triple-DES:
  - encrypt: C = E_k1(D_k2(E_k1(P)))
  - decrypt: P = D_k1(E_k2(D_k1(C)))
  - Standard FIPS 46-3 DES: IP, 16 Feistel rounds, swap, FP.
  - Key schedule: PC1, left rotates {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}, PC2. Decrypt uses subkeys in reverse order.
- FSM: IDLE -> PASS1 -> PASS2 -> PASS3 -> DONE -> IDLE.
  - Each pass is exactly 16 cycles, one round per cycle.
  - IP is applied combinationally when a pass loads; FP is applied combinationally at pass end.
  - Pass output feeds the next pass input.
- Latency: 48 cycles after the 8th-byte capture edge.
  - In DONE, i2c_output is loaded and output_ready asserts on the 49th edge.
  - output_ready stays high, and i2c_output holds, until the next data byte is captured or reset.
- Simultaneous events: i2c_stop toggling while busy does not affect the running computation; it only changes which counter accepts later bytes.
- i2c_output does not change except on completion or reset.

Decomposition:
- Package des_pkg holds:
  - DES permutation tables: IP, FP, E, P, PC1, PC2.
  - 8 S-boxes.
  - Rotate schedule.
  - FSM state enum typedef.
  - Functions permute() and sbox_lookup().
- Sub-module des_round (combinational):
  - Inputs: L, R, 48-bit subkey. Outputs: next L, R.
  - f = P(S(E(R) xor K)).
- Subkeys are generated iteratively in the top level: C/D registers rotated left for encrypt, right for decrypt.

Test Plan:
- Reset with rst=1 for 2 cycles -> output_ready=0, i2c_output=0.
- Single-DES check: key1=key2=133457799BBCDFF1 loaded as 16 strobed bytes (i2c_stop=0); i2c_stop=1; data 0123456789ABCDEF, i2c_rw=0 -> after 48 cycles output_ready=1, i2c_output=85E813540F0AB405.
- Second single-DES check: key1=key2=0E329232EA6D0D73; data 8787878787878787, encrypt -> 0000000000000000. Then decrypt 0000000000000000 -> 8787878787878787.
- Round trip: key1=3b3898371520f75e, key2=8c1f609efca32a78, data 1234567890abcdef.
  - Encrypt gives C with C != plaintext.
  - Reload C as data with i2c_rw=1 -> output 1234567890abcdef.
- Robustness:
  - Data strobes during busy are ignored; output_ready only pulses up once.
  - First new data byte clears output_ready.
  - Asserting rst at cycle 20 of computation -> no output_ready; all state zero.

Source files
------------

// File: rtl/des_pkg.sv
// DES constants, permutation/S-box helpers and FSM state encoding shared by
// the Triple-DES engine; tables are listed in FIPS 46-3 order (bit 1 = MSB).
package des_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PASS1 = 3'd1;
  localparam state_t ST_PASS2 = 3'd2;
  localparam state_t ST_PASS3 = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  typedef enum logic [2:0] {PERM_IP, PERM_FP, PERM_E, PERM_P, PERM_PC1, PERM_PC2} perm_t;

  // Bit r set means round r rotates by one position, otherwise by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Result is right-aligned; the source operand is right-aligned in din too.
  function automatic logic [63:0] permute(input logic [63:0] din, input perm_t sel);
    logic [63:0] res;
    res = '0;
    case (sel)
      PERM_IP:  for (int i = 0; i < 64; i++) res[63-i] = din[64-IP_T[i]];
      PERM_FP:  for (int i = 0; i < 64; i++) res[63-i] = din[64-FP_T[i]];
      PERM_E:   for (int i = 0; i < 48; i++) res[47-i] = din[32-E_T[i]];
      PERM_P:   for (int i = 0; i < 32; i++) res[31-i] = din[32-P_T[i]];
      PERM_PC1: for (int i = 0; i < 56; i++) res[55-i] = din[64-PC1_T[i]];
      PERM_PC2: for (int i = 0; i < 48; i++) res[47-i] = din[56-PC2_T[i]];
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Row comes from the outer bits, column from the inner four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] b);
    return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: l_next = r, r_next = l ^ P(S(E(r) ^ k)).
// Zero latency, no flow control.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [47:0] e48;
  logic [47:0] x;
  logic [31:0] s;
  logic [31:0] f;

  always_comb begin
    e48 = 48'(permute({32'b0, r}, PERM_E));
    x   = e48 ^ k;
    s   = '0;
    for (int i = 0; i < 8; i++) s[31-4*i -: 4] = sbox_lookup(3'(i), x[47-6*i -: 6]);
    f      = 32'(permute({32'b0, s}, PERM_P));
    l_next = r;
    r_next = l ^ f;
  end

endmodule

// File: rtl/encryption.sv
// Byte-serial two-key Triple-DES (EDE/DED), one round per cycle; result is
// registered 49 edges after the 8th data byte. Strobes while busy are dropped.
module encryption
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_stop,
  input  logic        i2c_rw,
  input  logic [7:0]  i2c_input,
  input  logic        read_enable,
  output logic [63:0] i2c_output,
  output logic        output_ready
);

  logic [63:0] key1, key2, data_reg, blk_reg;
  logic [3:0]  kcnt;
  logic [2:0]  dcnt;
  state_t      state;
  logic [3:0]  rnd;
  logic        rw_lat;
  logic [31:0] l_reg, r_reg;
  logic [27:0] c_reg, d_reg;

  logic        busy, cap_key, cap_data;
  logic        pass_dec;
  logic [63:0] pass_key, pass_in, ip_v, fp_v;
  logic [55:0] pc1_v;
  logic [31:0] l_in, r_in, l_out, r_out;
  logic [27:0] c_in, d_in, c_key, d_key, c_nxt, d_nxt;
  logic [47:0] subkey;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  assign busy     = (state != ST_IDLE);
  assign cap_key  = read_enable && !busy && !i2c_stop;
  assign cap_data = read_enable && !busy && i2c_stop;

  // Pass 2 runs the opposite direction with key2; round 0 loads a fresh block and key.
  always_comb begin
    pass_dec = rw_lat ^ (state == ST_PASS2);
    pass_key = (state == ST_PASS2) ? key2 : key1;
    pass_in  = (state == ST_PASS1) ? data_reg : blk_reg;
    ip_v     = permute(pass_in, PERM_IP);
    pc1_v    = 56'(permute(pass_key, PERM_PC1));
    l_in     = (rnd == 4'd0) ? ip_v[63:32] : l_reg;
    r_in     = (rnd == 4'd0) ? ip_v[31:0]  : r_reg;
    c_in     = (rnd == 4'd0) ? pc1_v[55:28] : c_reg;
    d_in     = (rnd == 4'd0) ? pc1_v[27:0]  : d_reg;
    if (pass_dec) begin
      // K16 equals the unrotated PC1 halves, so decrypt uses then rotates right.
      c_key = c_in;
      d_key = d_in;
      c_nxt = rotr28(c_in, SHIFT_ONE[4'd15 - rnd]);
      d_nxt = rotr28(d_in, SHIFT_ONE[4'd15 - rnd]);
    end else begin
      c_key = rotl28(c_in, SHIFT_ONE[rnd]);
      d_key = rotl28(d_in, SHIFT_ONE[rnd]);
      c_nxt = c_key;
      d_nxt = d_key;
    end
    subkey = 48'(permute({8'b0, c_key, d_key}, PERM_PC2));
    fp_v   = permute({r_out, l_out}, PERM_FP);
  end

  des_round u_round (
    .l      (l_in),
    .r      (r_in),
    .k      (subkey),
    .l_next (l_out),
    .r_next (r_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key1         <= '0;
      key2         <= '0;
      data_reg     <= '0;
      blk_reg      <= '0;
      kcnt         <= '0;
      dcnt         <= '0;
      state        <= ST_IDLE;
      rnd          <= '0;
      rw_lat       <= 1'b0;
      l_reg        <= '0;
      r_reg        <= '0;
      c_reg        <= '0;
      d_reg        <= '0;
      i2c_output   <= '0;
      output_ready <= 1'b0;
    end else begin
      if (i2c_stop) kcnt <= '0;
      else if (cap_key) begin
        if (!kcnt[3]) key1 <= {key1[55:0], i2c_input};
        else          key2 <= {key2[55:0], i2c_input};
        kcnt <= kcnt + 4'd1;
      end

      if (!i2c_stop) dcnt <= '0;
      else if (cap_data) begin
        data_reg     <= {data_reg[55:0], i2c_input};
        dcnt         <= dcnt + 3'd1;
        output_ready <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cap_data && dcnt == 3'd7) begin
            rw_lat <= i2c_rw;
            rnd    <= '0;
            state  <= ST_PASS1;
          end
        end
        ST_PASS1, ST_PASS2, ST_PASS3: begin
          l_reg <= l_out;
          r_reg <= r_out;
          c_reg <= c_nxt;
          d_reg <= d_nxt;
          rnd   <= rnd + 4'd1;
          if (rnd == 4'd15) begin
            blk_reg <= fp_v;
            state   <= (state == ST_PASS1) ? ST_PASS2 :
                       (state == ST_PASS2) ? ST_PASS3 : ST_DONE;
          end
        end
        ST_DONE: begin
          i2c_output   <= blk_reg;
          output_ready <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encryption.sv
// Scoreboard bench for the Triple-DES engine: stimulus pushes expected blocks
// and completion cycles, a negedge monitor pops them when output_ready rises.
module tb_encryption;
  import des_pkg::*;

  logic        tb_clk = 1'b0;
  logic        rst, i2c_stop, i2c_rw, read_enable;
  logic [7:0]  i2c_input;
  logic [63:0] i2c_output;
  logic        output_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] exp_q [$];
  int          lat_q [$];
  logic [63:0] cur_k1, cur_k2;
  logic        prev_rdy = 1'b0;
  logic [63:0] prev_out = '0;

  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  encryption dut (
    .clk          (tb_clk),
    .rst          (rst),
    .i2c_stop     (i2c_stop),
    .i2c_rw       (i2c_rw),
    .i2c_input    (i2c_input),
    .read_enable  (read_enable),
    .i2c_output   (i2c_output),
    .output_ready (output_ready)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  // Textbook single DES: precomputed subkey array, then 16 Feistel rounds.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] ipb, pre, res;
    logic [31:0] l, r, t, f, sout;
    logic [47:0] x, k;
    logic [5:0]  six;
    logic [1:0]  row;
    logic [3:0]  col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SH[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) ipb[63-i] = blk[64-IP_T[i]];
    l = ipb[63:32];
    r = ipb[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      k = dec ? ks[15-rd] : ks[rd];
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
      x = x ^ k;
      for (int j = 0; j < 8; j++) begin
        six = x[47-6*j -: 6];
        row = {six[5], six[0]};
        col = six[4:1];
        sout[31-4*j -: 4] = 4'(SBOX[j][{row, col}]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  function automatic logic [63:0] tdes_ref(input logic [63:0] k1, input logic [63:0] k2,
                                           input logic [63:0] d, input bit dec);
    return des_ref(k1, des_ref(k2, des_ref(k1, d, dec), !dec), dec);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic rw);
    @(posedge tb_clk);
    #1;
    read_enable = 1'b1;
    i2c_input   = b;
    i2c_stop    = stop;
    i2c_rw      = rw;
    @(posedge tb_clk);
    #1;
    read_enable = 1'b0;
  endtask

  task automatic load_keys(input logic [63:0] k1, input logic [63:0] k2);
    for (int i = 0; i < 8; i++) send_byte(k1[63-8*i -: 8], 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(k2[63-8*i -: 8], 1'b0, 1'b0);
    cur_k1 = k1;
    cur_k2 = k2;
  endtask

  // Returns just after the capture edge of the 8th byte.
  task automatic send_block(input logic [63:0] d, input logic rw, input logic [63:0] exp);
    for (int i = 0; i < 8; i++) send_byte(d[63-8*i -: 8], 1'b1, rw);
    exp_q.push_back(exp);
    lat_q.push_back(cyc + 49);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge tb_clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL done_timeout: got %0d pending results want 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge tb_clk);
  endtask

  always @(negedge tb_clk) begin
    if (!rst) begin
      if (output_ready && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got ready=1 want 0 (cycle %0d)", cyc);
        end else begin
          chk("result", i2c_output, exp_q.pop_front());
          chk("latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
      end else if (i2c_output !== prev_out) begin
        total++;
        bad++;
        $display("FAIL out_changed: got %h want %h", i2c_output, prev_out);
      end
    end
    prev_rdy = output_ready;
    prev_out = i2c_output;
  end

  initial begin
    logic [63:0] k1, k2, d, c, held, nb;
    logic        rw;
    rst = 1'b1; read_enable = 1'b0; i2c_stop = 1'b0; i2c_rw = 1'b0; i2c_input = '0;
    cur_k1 = '0; cur_k2 = '0;
    repeat (2) @(posedge tb_clk);
    #1 rst = 1'b0;
    @(negedge tb_clk);
    chk("reset_ready", 64'(output_ready), 64'd0);
    chk("reset_out", i2c_output, 64'd0);

    // Known answers: equal keys reduce EDE to single DES.
    load_keys(64'h133457799BBCDFF1, 64'h133457799BBCDFF1);
    send_block(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    wait_done();
    load_keys(64'h0E329232EA6D0D73, 64'h0E329232EA6D0D73);
    send_block(64'h8787878787878787, 1'b0, 64'h0000000000000000);
    wait_done();
    send_block(64'h0000000000000000, 1'b1, 64'h8787878787878787);
    wait_done();

    // Two-key round trip through the DUT's own ciphertext.
    load_keys(64'h3b3898371520f75e, 64'h8c1f609efca32a78);
    send_block(64'h1234567890abcdef, 1'b0, tdes_ref(cur_k1, cur_k2, 64'h1234567890abcdef, 1'b0));
    wait_done();
    c = i2c_output;
    total++;
    if (c === 64'h1234567890abcdef) begin
      bad++;
      $display("FAIL cipher_differs: got %h want anything else", c);
    end
    send_block(c, 1'b1, 64'h1234567890abcdef);
    wait_done();

    for (int it = 0; it < 6; it++) begin
      k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      load_keys(k1, k2);
      send_block(d, rw, tdes_ref(k1, k2, d, rw));
      wait_done();
    end

    // Strobes while busy in both phases must be dropped.
    d = {$urandom, $urandom};
    send_block(d, 1'b0, tdes_ref(cur_k1, cur_k2, d, 1'b0));
    for (int i = 0; i < 20; i++)
      send_byte(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_done();

    // First new data byte clears ready while the old result holds.
    held = i2c_output;
    nb = {$urandom, $urandom};
    send_byte(nb[63:56], 1'b1, 1'b0);
    @(negedge tb_clk);
    chk("ready_cleared", 64'(output_ready), 64'd0);
    chk("output_held", i2c_output, held);
    for (int i = 1; i < 8; i++) send_byte(nb[63-8*i -: 8], 1'b1, 1'b1);
    exp_q.push_back(tdes_ref(cur_k1, cur_k2, nb, 1'b1));
    lat_q.push_back(cyc + 49);
    wait_done();

    // Key counter restarts when the data phase is entered.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    @(posedge tb_clk);
    #1 i2c_stop = 1'b1;
    @(posedge tb_clk);
    load_keys({$urandom, $urandom}, {$urandom, $urandom});
    // Data counter restarts when the key phase is entered.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    @(posedge tb_clk);
    #1 i2c_stop = 1'b0;
    @(posedge tb_clk);
    d = {$urandom, $urandom};
    send_block(d, 1'b0, tdes_ref(cur_k1, cur_k2, d, 1'b0));
    wait_done();

    // Reset 20 cycles into a computation aborts it and clears the keys.
    d = {$urandom, $urandom};
    send_block(d, 1'b1, tdes_ref(cur_k1, cur_k2, d, 1'b1));
    repeat (19) @(posedge tb_clk);
    #1 rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge tb_clk);
    #1 rst = 1'b0;
    @(negedge tb_clk);
    chk("abort_ready", 64'(output_ready), 64'd0);
    chk("abort_out", i2c_output, 64'd0);
    repeat (80) @(posedge tb_clk);
    cur_k1 = '0;
    cur_k2 = '0;
    d = {$urandom, $urandom};
    send_block(d, 1'b0, tdes_ref(64'd0, 64'd0, d, 1'b0));
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
